mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port (m0) and the load/store port (m1). Load/store has fixed priority, but a
// starvation counter forces a fetch grant after STARVE_MAX consecutive m1 wins.
// Optional protocol checker: define ARB_PROTOCOL_CHECK_EN to build proto_err.
module mem_arbiter #(
   parameter int ADDR_W      = 24,
   parameter int MEM_LATENCY = 1,
   parameter int STARVE_MAX  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic              m0_rstrb,
   output logic [31:0]       m0_rdata,
   output logic              m0_rbusy,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_wmask,
   input  logic              m1_rstrb,
   output logic [31:0]       m1_rdata,
   output logic              m1_rbusy,
   output logic              m1_wbusy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wmask,
   output logic              mem_rstrb,
   input  logic [31:0]       mem_rdata,
   output logic              proto_err
);

   localparam int WCNT_W = $clog2(MEM_LATENCY + 1);
   localparam int STRV_W = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t              state;
   state_t              next_state;

   logic                p0_valid;
   logic [ADDR_W-1:0]   p0_addr;
   logic                p1_valid;
   logic [ADDR_W-1:0]   p1_addr;
   logic [31:0]         p1_wdata;
   logic [3:0]          p1_wmask;

   logic                cur_m1;
   logic                cur_write;
   logic [WCNT_W-1:0]   wait_cnt;
   logic [STRV_W-1:0]   starve_cnt;

   logic                wait_last;
   logic                m1_wr_req;
   logic                m1_any;
   logic                m0_done;
   logic                m1_done;
   logic                m0_take;
   logic                m1_take;
   logic                req0;
   logic                req1;
   logic [ADDR_W-1:0]   addr0;
   logic [ADDR_W-1:0]   addr1;
   logic [31:0]         wdata1;
   logic [3:0]          wmask1;
   logic                starve_full;
   logic                sel_m1;
   logic                grant;
   logic                grant_m0;
   logic                grant_m1;
   logic                grant_write;

   // A port whose transaction completes this cycle is free again, so a new
   // strobe in its completion cycle is accepted; this keeps back-to-back
   // traffic at zero idle cycles and lets m1 compete at every grant.
   always_comb begin
      wait_last   = (wait_cnt == '0);
      m1_wr_req   = (m1_wmask != 4'b0000);
      m1_any      = m1_wr_req || m1_rstrb;
      m0_done     = (state == WAIT) && wait_last && !cur_m1;
      m1_done     = ((state == WAIT) && wait_last && cur_m1) ||
                    ((state == ISSUE) && cur_write);
      m0_take     = m0_rstrb && (!m0_rbusy || m0_done);
      m1_take     = m1_any && (!(m1_rbusy || m1_wbusy) || m1_done);
      req0        = p0_valid || m0_take;
      req1        = p1_valid || m1_take;
      addr0       = p0_valid ? p0_addr  : m0_addr;
      addr1       = p1_valid ? p1_addr  : m1_addr;
      wdata1      = p1_valid ? p1_wdata : m1_wdata;
      wmask1      = p1_valid ? p1_wmask : m1_wmask;
      starve_full = (starve_cnt == STRV_W'(STARVE_MAX));
      sel_m1      = req1 && !(req0 && starve_full);
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   // Next-state logic; a grant happens at every decision point with a request.
   always_comb begin
      next_state = state;
      grant      = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               grant      = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE: begin
            if (!cur_write) begin
               next_state = WAIT;
            end else if (req0 || req1) begin
               grant      = 1'b1;
               next_state = ISSUE;
            end else begin
               next_state = IDLE;
            end
         end
         WAIT: begin
            if (wait_last) begin
               if (req0 || req1) begin
                  grant      = 1'b1;
                  next_state = ISSUE;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
      grant_m1    = grant && sel_m1;
      grant_m0    = grant && !sel_m1;
      grant_write = grant_m1 && (wmask1 != 4'b0000);
   end

   // Tracks the transaction in flight and counts down the read latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_m1    <= 1'b0;
         cur_write <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         if (grant) begin
            cur_m1    <= sel_m1;
            cur_write <= grant_write;
         end
         if (state == ISSUE && !cur_write)
            wait_cnt <= WCNT_W'(MEM_LATENCY - 1);
         else if (state == WAIT && !wait_last)
            wait_cnt <= wait_cnt - 1'b1;
      end
   end

   // Registered memory strobes; address and write data hold between issues.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= 4'b0000;
         mem_rstrb <= 1'b0;
      end else begin
         mem_rstrb <= grant && !grant_write;
         mem_wmask <= grant_write ? wmask1 : 4'b0000;
         if (grant)
            mem_addr <= sel_m1 ? addr1 : addr0;
         if (grant_write)
            mem_wdata <= wdata1;
      end
   end

   // Pending slots hold requests that were accepted but not granted at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p0_valid <= 1'b0;
         p0_addr  <= '0;
         p1_valid <= 1'b0;
         p1_addr  <= '0;
         p1_wdata <= '0;
         p1_wmask <= 4'b0000;
      end else begin
         if (m0_take && !grant_m0) begin
            p0_valid <= 1'b1;
            p0_addr  <= m0_addr;
         end else if (grant_m0) begin
            p0_valid <= 1'b0;
         end
         if (m1_take && !grant_m1) begin
            p1_valid <= 1'b1;
            p1_addr  <= m1_addr;
            p1_wdata <= m1_wdata;
            p1_wmask <= m1_wmask;
         end else if (grant_m1) begin
            p1_valid <= 1'b0;
         end
      end
   end

   // Busy flags rise after an accepted strobe and fall after completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0_rbusy <= 1'b0;
         m1_rbusy <= 1'b0;
         m1_wbusy <= 1'b0;
      end else begin
         m0_rbusy <= (m0_rbusy && !m0_done) || m0_take;
         m1_rbusy <= (m1_rbusy && !(m1_done && !cur_write)) || (m1_take && !m1_wr_req);
         m1_wbusy <= (m1_wbusy && !(m1_done && cur_write)) || (m1_take && m1_wr_req);
      end
   end

   // Read data is captured on the last wait cycle and held until the next read.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else begin
         if (m0_done)
            m0_rdata <= mem_rdata;
         if (m1_done && !cur_write)
            m1_rdata <= mem_rdata;
      end
   end

   // Starvation counter: counts m1 wins over a waiting m0, cleared by an m0 win.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         starve_cnt <= '0;
      else if (grant_m0)
         starve_cnt <= '0;
      else if (grant_m1 && req0 && !starve_full)
         starve_cnt <= starve_cnt + 1'b1;
   end

`ifdef ARB_PROTOCOL_CHECK_EN
   logic first_cycle;
   logic err_m0_busy;
   logic err_m1_busy;
   logic err_m1_both;
   logic err_release;

   assign err_m0_busy = m0_rstrb && m0_rbusy && !m0_done;
   assign err_m1_busy = m1_any && (m1_rbusy || m1_wbusy) && !m1_done;
   assign err_m1_both = m1_rstrb && m1_wr_req;
   assign err_release = first_cycle && m0_rstrb && m1_rstrb;

   // Sticky violation flag; first_cycle marks the cycle right after reset release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         first_cycle <= 1'b1;
         proto_err   <= 1'b0;
      end else begin
         first_cycle <= 1'b0;
         proto_err   <= proto_err || err_m0_busy || err_m1_busy || err_m1_both || err_release;
      end
   end

`ifndef SYNTHESIS
   // Simulation-only reporting of each violation with its port.
   always @(posedge clk) begin
      if (rst) begin
         if (err_m0_busy) $display("%0t mem_arbiter protocol: strobe on busy port m0", $time);
         if (err_m1_busy) $display("%0t mem_arbiter protocol: strobe on busy port m1", $time);
         if (err_m1_both) $display("%0t mem_arbiter protocol: read and write together on m1", $time);
         if (err_release) $display("%0t mem_arbiter protocol: m0 and m1 strobes at reset release", $time);
      end
   end
`endif
`else
   assign proto_err = 1'b0;
`endif

endmodule
